// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: issues aligned word accesses over a
// req/gnt/rvalid data-memory bus, lane-shifts store data, and aligns and
// extends load data into mem_data for writeback. The pipeline is stalled
// while an access is outstanding, and misaligned accesses are rejected
// without any bus activity.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic              done,
    output logic              misaligned,
    output logic [31:0]       mem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic        start;
    logic        aligned;
    logic        accept;
    logic        reject;
    logic        stall_fsm;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [31:0] load_shifted;
    logic [31:0] load_ext;

    // Latched per-access context needed after the accept cycle
    logic [2:0]  op_funct3;
    logic [1:0]  op_lane;
    logic        op_load;

    // A simultaneous load+store is treated as a load
    assign start  = ex_valid & (is_load | is_store);
    assign accept = start & aligned & (state == IDLE);
    assign reject = start & ~aligned & (state == IDLE);

    // Size/alignment legality; unused size/sign encodings count as misaligned
    always_comb begin
        aligned = 1'b0;
        unique case (funct3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~addr[0];
            3'b010:         aligned = (addr[1:0] == 2'b00);
            default:        aligned = 1'b0;
        endcase
    end

    // Store lane replication and byte enables (loads reuse the size-based enables)
    always_comb begin
        lane_wdata = 32'h0;
        lane_be    = 4'h0;
        unique case (funct3[1:0])
            2'b00: begin
                lane_wdata = {4{store_data[7:0]}};
                lane_be    = 4'(4'b0001 << addr[1:0]);
            end
            2'b01: begin
                lane_wdata = {2{store_data[15:0]}};
                lane_be    = 4'(4'b0011 << addr[1:0]);
            end
            default: begin
                lane_wdata = store_data;
                lane_be    = 4'b1111;
            end
        endcase
        if (is_load) begin
            lane_wdata = 32'h0;
        end
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        load_shifted = dmem_rdata >> {op_lane, 3'b000};
        load_ext     = dmem_rdata;
        unique case (op_funct3)
            3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b100:  load_ext = {24'h0, load_shifted[7:0]};
            3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b101:  load_ext = {16'h0, load_shifted[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and combinational stall
    always_comb begin
        state_next = state;
        stall_fsm  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = REQ;
                    stall_fsm  = 1'b1;
                end
            end
            REQ: begin
                stall_fsm = 1'b1;
                if (dmem_gnt) begin
                    state_next = op_load ? WAIT : DONE;
                end
            end
            WAIT: begin
                stall_fsm = 1'b1;
                if (dmem_rvalid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is held, even if execute is requesting
    assign stall = stall_fsm & ~rst;

    // Registered outputs and latched access context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            mem_data   <= 32'h0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= 32'h0;
            dmem_be    <= 4'h0;
            op_funct3  <= 3'b000;
            op_lane    <= 2'b00;
            op_load    <= 1'b0;
        end else begin
            dmem_req   <= (state_next == REQ);
            done       <= (state_next == DONE);
            misaligned <= reject;
            if (accept) begin
                dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                dmem_we    <= is_store & ~is_load;
                dmem_wdata <= lane_wdata;
                dmem_be    <= lane_be;
                op_funct3  <= funct3;
                op_lane    <= addr[1:0];
                op_load    <= is_load;
            end
            if ((state == WAIT) && dmem_rvalid) begin
                mem_data <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: stores, loads with extension,
// misaligned rejection, gnt backpressure and reset during an access.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        done;
    logic        misaligned;
    logic [31:0] mem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .is_load     (is_load),
        .is_store    (is_store),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .stall       (stall),
        .done        (done),
        .misaligned  (misaligned),
        .mem_data    (mem_data),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge, away from the active edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        ex_valid   = 1'b1;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        ex_valid    = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        funct3      = 3'b000;
        addr        = 32'h0;
        store_data  = 32'h0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'h0);
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_we", 32'(dmem_we), 32'h0);
        chk("rst_mem_data", mem_data, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_be", 32'(dmem_be), 32'h0);
        #3 rst = 1'b0;
        tick();

        // SW 0x104, gnt held high: stall 2 cycles, done on the third
        dmem_gnt = 1'b1;
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
        #1 chk("sw_accept_stall", 32'(stall), 32'h1);
        tick();
        chk("sw_req", 32'(dmem_req), 32'h1);
        chk("sw_addr", dmem_addr, 32'h0000_0104);
        chk("sw_be", 32'(dmem_be), 32'hF);
        chk("sw_we", 32'(dmem_we), 32'h1);
        chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        chk("sw_req_stall", 32'(stall), 32'h1);
        tick();
        chk("sw_done", 32'(done), 32'h1);
        chk("sw_done_req", 32'(dmem_req), 32'h0);
        chk("sw_mem_data", mem_data, 32'h0);
        // Present SB during DONE: must not be accepted until IDLE
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5);
        #1 chk("done_no_accept_stall", 32'(stall), 32'h0);
        tick();
        chk("done_pulse_end", 32'(done), 32'h0);
        chk("idle_no_req", 32'(dmem_req), 32'h0);
        chk("sb_accept_stall", 32'(stall), 32'h1);

        // SB 0x203
        tick();
        chk("sb_req", 32'(dmem_req), 32'h1);
        chk("sb_be", 32'(dmem_be), 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", dmem_addr, 32'h0000_0200);
        tick();
        chk("sb_done", 32'(done), 32'h1);
        idle_ex();
        tick();

        // LB 0x302, rvalid two cycles after gnt
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0302, 32'h0);
        tick();
        chk("lb_req", 32'(dmem_req), 32'h1);
        chk("lb_we", 32'(dmem_we), 32'h0);
        chk("lb_addr", dmem_addr, 32'h0000_0300);
        chk("lb_be", 32'(dmem_be), 32'h4);
        tick();
        dmem_gnt = 1'b0;
        chk("lb_wait_req", 32'(dmem_req), 32'h0);
        chk("lb_wait_stall", 32'(stall), 32'h1);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12F4_5678;
        chk("lb_wait2_done", 32'(done), 32'h0);
        tick();
        dmem_rvalid = 1'b0;
        chk("lb_done", 32'(done), 32'h1);
        chk("lb_data", mem_data, 32'hFFFF_FFF4);
        chk("lb_done_stall", 32'(stall), 32'h0);
        idle_ex();
        tick();

        // LBU 0x302; rvalid coinciding with gnt must be ignored
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0302, 32'h0);
        tick();
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0000_DEAD;
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        chk("lbu_early_rvalid_done", 32'(done), 32'h0);
        chk("lbu_early_rvalid_stall", 32'(stall), 32'h1);
        chk("lbu_hold_data", mem_data, 32'hFFFF_FFF4);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12F4_5678;
        tick();
        dmem_rvalid = 1'b0;
        chk("lbu_done", 32'(done), 32'h1);
        chk("lbu_data", mem_data, 32'h0000_00F4);
        idle_ex();
        tick();

        // LH 0x402
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0402, 32'h0);
        dmem_gnt = 1'b1;
        tick();
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h8001_7FFF;
        tick();
        dmem_rvalid = 1'b0;
        chk("lh_done", 32'(done), 32'h1);
        chk("lh_data", mem_data, 32'hFFFF_8001);
        idle_ex();
        tick();

        // Misaligned LW 0x101
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
        #1 chk("mis_stall", 32'(stall), 32'h0);
        tick();
        idle_ex();
        chk("mis_pulse", 32'(misaligned), 32'h1);
        chk("mis_no_req", 32'(dmem_req), 32'h0);
        tick();
        chk("mis_pulse_end", 32'(misaligned), 32'h0);
        chk("mis_still_no_req", 32'(dmem_req), 32'h0);

        // Illegal funct3 011 is rejected as misaligned
        issue(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
        #1 chk("ill_stall", 32'(stall), 32'h0);
        tick();
        idle_ex();
        chk("ill_pulse", 32'(misaligned), 32'h1);
        chk("ill_no_req", 32'(dmem_req), 32'h0);
        tick();

        // Misaligned SH 0x001, then the LH result must be untouched
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0);
        tick();
        idle_ex();
        chk("sh_mis_pulse", 32'(misaligned), 32'h1);
        chk("sh_mis_data_hold", mem_data, 32'hFFFF_8001);
        tick();

        // SH 0x506 under gnt backpressure for 5 cycles
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0506, 32'h0000_BEEF);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_req", 32'(dmem_req), 32'h1);
            chk("bp_addr", dmem_addr, 32'h0000_0504);
            chk("bp_be", 32'(dmem_be), 32'hC);
            chk("bp_wdata", dmem_wdata, 32'hBEEF_BEEF);
            chk("bp_stall", 32'(stall), 32'h1);
            tick();
        end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("bp_done", 32'(done), 32'h1);
        chk("bp_store_data_hold", mem_data, 32'hFFFF_8001);
        idle_ex();
        tick();

        // LW 0x600, reset asserted during WAIT with execute still requesting
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0);
        dmem_gnt = 1'b1;
        tick();
        tick();
        dmem_gnt = 1'b0;
        chk("rw_wait_stall", 32'(stall), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rw_stall", 32'(stall), 32'h0);
        chk("rw_req", 32'(dmem_req), 32'h0);
        chk("rw_done", 32'(done), 32'h0);
        chk("rw_we", 32'(dmem_we), 32'h0);
        chk("rw_addr", dmem_addr, 32'h0);
        chk("rw_wdata", dmem_wdata, 32'h0);
        chk("rw_be", 32'(dmem_be), 32'h0);
        chk("rw_mem_data", mem_data, 32'h0);
        chk("rw_misaligned", 32'(misaligned), 32'h0);
        idle_ex();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        tick();
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_done", 32'(done), 32'h0);
            chk("post_rst_req", 32'(dmem_req), 32'h0);
            chk("post_rst_data", mem_data, 32'h0);
        end
        dmem_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
